// File: rtl/sum_accumulator.sv
// Accumulates N_SAMPLES unsigned 5-bit sums into an ACC_W-bit result with a sticky overflow flag.
// Define SUM_ACCUMULATOR_SATURATE_EN to clamp on overflow instead of wrapping.
module sum_accumulator #(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       sum_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr,
    output logic [ACC_W-1:0] acc_out,
    output logic [7:0]       cnt,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam logic [7:0] N_LAST = 8'(N_SAMPLES);

    state_t           r_state;
    state_t           w_nextState;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic             r_ovf;

    logic             w_beat;
    logic             w_lastBeat;
    logic             w_clearAll;
    logic [7:0]       w_cntInc;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_accNext;

    assign in_ready  = (r_state == ACC);
    assign out_valid = (r_state == DONE);
    assign acc_out   = r_acc;
    assign cnt       = r_cnt;
    assign ovf       = r_ovf;

    assign w_beat     = in_valid && in_ready;
    assign w_cntInc   = r_cnt + 8'd1;
    assign w_lastBeat = (w_cntInc == N_LAST);
    assign w_clearAll = clr || ((r_state == DONE) && out_ready);

    // The extra top bit of w_sum is the carry that marks an overflowing beat.
    assign w_sum = {1'b0, r_acc} + {{(ACC_W-4){1'b0}}, sum_in};

`ifdef SUM_ACCUMULATOR_SATURATE_EN
    assign w_accNext = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_accNext = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACC;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (clr) begin
            w_nextState = ACC;
        end else begin
            case (r_state)
                ACC:     if (w_beat && w_lastBeat) w_nextState = DONE;
                DONE:    if (out_ready) w_nextState = ACC;
                default: w_nextState = ACC;
            endcase
        end
    end

    // Clear on abort or consumed result; otherwise only an accepted beat changes the datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_clearAll) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_beat) begin
            r_acc <= w_accNext;
            r_cnt <= w_cntInc;
            r_ovf <= r_ovf | w_sum[ACC_W];
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: three sum_accumulator instances (default, ACC_W=6, N_SAMPLES=1) share
// stimulus and are compared every cycle against a true-sum reference model.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       out_ready;
    logic [4:0] sum_in;

    logic [2:0] inReady;
    logic [2:0] outValid;
    logic [2:0] ovfObs;
    logic [7:0] cntObs [3];
    logic [7:0] acc0;
    logic [5:0] acc1;
    logic [7:0] acc2;

    int checks = 0;
    int errors = 0;

    localparam int NS [3] = '{4, 4, 1};
    localparam int WS [3] = '{8, 6, 8};

    int mSum  [3];
    int mCnt  [3];
    bit mDone [3];

    always #5 clk = ~clk;

    sum_accumulator dut0 (
        .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .in_valid(in_valid), .in_ready(inReady[0]),
        .clr(clr), .acc_out(acc0), .cnt(cntObs[0]), .ovf(ovfObs[0]), .out_valid(outValid[0]),
        .out_ready(out_ready)
    );

    sum_accumulator #(.N_SAMPLES(4), .ACC_W(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .in_valid(in_valid), .in_ready(inReady[1]),
        .clr(clr), .acc_out(acc1), .cnt(cntObs[1]), .ovf(ovfObs[1]), .out_valid(outValid[1]),
        .out_ready(out_ready)
    );

    sum_accumulator #(.N_SAMPLES(1), .ACC_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .in_valid(in_valid), .in_ready(inReady[2]),
        .clr(clr), .acc_out(acc2), .cnt(cntObs[2]), .ovf(ovfObs[2]), .out_valid(outValid[2]),
        .out_ready(out_ready)
    );

    // Reference: keep the unbounded true sum and derive the visible result from it.
    function automatic int expAcc(input int k);
        int maxv;
        maxv = (1 << WS[k]) - 1;
        if (mSum[k] <= maxv) return mSum[k];
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        return maxv;
`else
        return mSum[k] % (maxv + 1);
`endif
    endfunction

    task automatic modelStep();
        for (int k = 0; k < 3; k++) begin
            if (!rst_n || clr) begin
                mSum[k] = 0; mCnt[k] = 0; mDone[k] = 0;
            end else if (mDone[k]) begin
                if (out_ready) begin
                    mSum[k] = 0; mCnt[k] = 0; mDone[k] = 0;
                end
            end else if (in_valid) begin
                mSum[k] += int'(sum_in);
                mCnt[k] += 1;
                if (mCnt[k] == NS[k]) mDone[k] = 1;
            end
        end
    endtask

    task automatic checkOne(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        int accObs [3];
        accObs[0] = int'(acc0);
        accObs[1] = int'(acc1);
        accObs[2] = int'(acc2);
        for (int k = 0; k < 3; k++) begin
            checkOne($sformatf("%s/u%0d/in_ready", tag, k), int'(inReady[k]), int'(!mDone[k]));
            checkOne($sformatf("%s/u%0d/out_valid", tag, k), int'(outValid[k]), int'(mDone[k]));
            checkOne($sformatf("%s/u%0d/cnt", tag, k), int'(cntObs[k]), mCnt[k]);
            checkOne($sformatf("%s/u%0d/acc", tag, k), accObs[k], expAcc(k));
            checkOne($sformatf("%s/u%0d/ovf", tag, k), int'(ovfObs[k]),
                     int'(mSum[k] > ((1 << WS[k]) - 1)));
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare just after it.
    task automatic applyStimulus(input bit rn, input bit c, input bit v, input bit r,
                                 input int s, input string tag);
        rst_n     = rn;
        clr       = c;
        in_valid  = v;
        out_ready = r;
        sum_in    = 5'(s);
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        int gapVals [7];
        bit gapVld  [7];
        gapVals = '{1, 9, 2, 17, 30, 3, 4};
        gapVld  = '{1, 0, 1, 0, 0, 1, 1};
        for (int k = 0; k < 3; k++) begin
            mSum[k] = 0; mCnt[k] = 0; mDone[k] = 0;
        end

        applyStimulus(0, 0, 1, 0, 30, "reset");
        applyStimulus(0, 0, 0, 0, 0, "reset2");
        checkOne("reset_in_ready_const", int'(inReady[0]), 1);
        checkOne("reset_acc_const", int'(acc0), 0);

        // Four back-to-back beats of 30.
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 0, 30, "basic");
        checkOne("basic_acc_const", int'(acc0), 120);
        checkOne("basic_cnt_const", int'(cntObs[0]), 4);
        checkOne("basic_valid_const", int'(outValid[0]), 1);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        checkOne("corner30_w6_acc_const", int'(acc1), 63);
`else
        checkOne("corner30_w6_acc_const", int'(acc1), 56);
`endif
        checkOne("corner30_w6_ovf_const", int'(ovfObs[1]), 1);

        // Result held under back-pressure while in_valid stays high.
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 7, "hold");
        checkOne("hold_acc_const", int'(acc0), 120);
        applyStimulus(1, 0, 1, 1, 7, "handoff");
        applyStimulus(1, 0, 1, 0, 5, "afterHandoff");
        checkOne("afterHandoff_acc_const", int'(acc0), 5);
        applyStimulus(1, 1, 1, 0, 9, "clr");

        // Overflow with beats 31,31,31,0.
        applyStimulus(1, 0, 1, 0, 31, "ovf");
        applyStimulus(1, 0, 1, 0, 31, "ovf");
        applyStimulus(1, 0, 1, 0, 31, "ovf");
        applyStimulus(1, 0, 1, 0, 0, "ovf");
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        checkOne("ovf_w6_acc_const", int'(acc1), 63);
`else
        checkOne("ovf_w6_acc_const", int'(acc1), 29);
`endif
        checkOne("ovf_w6_flag_const", int'(ovfObs[1]), 1);
        applyStimulus(1, 0, 0, 1, 0, "consume");

        // Gapped input: values presented with in_valid low must be ignored.
        for (int i = 0; i < 7; i++) applyStimulus(1, 0, gapVld[i], 0, gapVals[i], "gap");
        checkOne("gap_acc_const", int'(acc0), 10);
        checkOne("gap_cnt_const", int'(cntObs[0]), 4);
        applyStimulus(1, 1, 0, 1, 0, "clr2");

        // Mid-accumulation reset, then mid-accumulation clr with a simultaneous beat.
        applyStimulus(1, 0, 1, 0, 5, "mid");
        applyStimulus(1, 0, 1, 0, 6, "mid");
        applyStimulus(0, 0, 1, 1, 30, "midReset");
        checkOne("midReset_cnt_const", int'(cntObs[0]), 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 0, 1, "ones");
        checkOne("ones_acc_const", int'(acc0), 4);
        applyStimulus(1, 0, 0, 1, 0, "consume2");
        applyStimulus(1, 0, 1, 0, 5, "mid2");
        applyStimulus(1, 0, 1, 0, 6, "mid2");
        applyStimulus(1, 1, 1, 1, 30, "midClr");
        checkOne("midClr_acc_const", int'(acc0), 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 0, 1, "ones2");
        checkOne("ones2_acc_const", int'(acc0), 4);

        // Randomized traffic with occasional clr and reset.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(63) != 0), ($urandom_range(31) == 0),
                          ($urandom_range(9) < 7), ($urandom_range(1) == 1),
                          int'($urandom_range(30)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL provide parameter: N_SAMPLES, default 4, number of sums accumulated per result (legal range 1..255).
REQ-002 SHALL provide parameter: ACC_W, default 8, accumulator and result width (legal range 6..16).
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port: sum_in  input  5  unsigned 5-bit sum produced by the upstream 4-bit adder (0..30).
REQ-006 SHALL have port: in_valid  input  1  sum_in is valid this cycle.
REQ-007 SHALL have port: in_ready  output  1  block accepts sum_in this cycle.
REQ-008 SHALL have port: clr  input  1  synchronous abort of the current accumulation.
REQ-009 SHALL have port: acc_out  output  ACC_W  accumulated result.
REQ-010 SHALL have port: cnt  output  8  number of beats accepted in the current accumulation.
REQ-011 SHALL have port: ovf  output  1  sticky flag: accumulation exceeded 2^ACC_W-1.
REQ-012 SHALL have port: out_valid  output  1  acc_out/ovf hold a completed result.
REQ-013 SHALL have port: out_ready  input  1  downstream consumes the result.

Function
REQ-014 SHALL implement a two-state FSM: ACC (collecting) and DONE (result held).
REQ-015 SHALL drive in_ready=1 only in ACC; out_valid=1 only in DONE; both are registered-state decodes, not combinational paths from in_valid/out_ready.
REQ-016 SHALL accept a beat when in_valid&&in_ready, adding zero-extended sum_in to the accumulator and incrementing cnt.
REQ-017 SHALL move ACC->DONE on the accepted beat that makes cnt==N_SAMPLES; out_valid rises the following cycle, with acc_out including that beat.
REQ-018 SHALL hold acc_out, cnt and ovf stable in DONE while out_ready=0.
REQ-019 SHALL, in DONE with out_ready=1, clear accumulator, cnt and ovf and return to ACC; in_ready rises the next cycle, and no beat is accepted in the handoff cycle.
REQ-020 SHALL set ovf when the true sum of the accepted beats exceeds 2^ACC_W-1; ovf stays set until the result is consumed, clr, or reset.
REQ-021 SHALL, with clr=1 in any state, clear accumulator, cnt and ovf and enter ACC next cycle; clr has priority over a simultaneous beat or out_ready.
REQ-022 SHALL ignore sum_in whenever in_valid=0 or in_ready=0; in_valid held high in DONE causes no state change.
REQ-023 SHALL, when N_SAMPLES=1, enter DONE on every accepted beat.

Reset
REQ-024 SHALL, on rising clk with rst_n=0, set state=ACC, acc_out=0, cnt=0, ovf=0, out_valid=0, in_ready=1 in the following cycle.
REQ-025 SHALL give reset priority over clr, beats and out_ready, including in the middle of an accumulation or while a result is held; a partial result is discarded.

Configuration
REQ-026 SHALL honour the macro SUM_ACCUMULATOR_SATURATE_EN.
REQ-027 SHALL, with SUM_ACCUMULATOR_SATURATE_EN defined, clamp the accumulator at 2^ACC_W-1 on overflow; ovf is still set.
REQ-028 SHALL, without SUM_ACCUMULATOR_SATURATE_EN, wrap the accumulator modulo 2^ACC_W on overflow; ovf is still set.

Verification
REQ-029 SHALL cover basic accumulation: N=4, ACC_W=8, beats 30,30,30,30 back-to-back -> out_valid one cycle after the 4th beat, acc_out=120, cnt=4, ovf=0.
REQ-030 SHALL cover overflow: ACC_W=6, N=4, beats 31,31,31,0 -> wrap build acc_out=29, ovf=1; SATURATE_EN build acc_out=63, ovf=1.
REQ-031 SHALL cover back-pressure: result held with out_ready=0 for 3 cycles while in_valid=1 -> acc_out/cnt unchanged, in_ready=0, no beat is lost; after out_ready=1, the next beat is accepted two cycles later.
REQ-032 SHALL cover gapped input: beats 1,_,2,_,_,3,4 (in_valid low in gaps) -> acc_out=10 and cnt=4, with gap values ignored.
REQ-033 SHALL cover mid-operation reset and clr: after beats 5,6, either rst_n=0 for one cycle or clr=1 -> cnt=0, acc_out=0, ovf=0; then beats 1,1,1,1 -> acc_out=4.
REQ-034 SHALL cover the exhaustive upstream corner: four beats of 30 (15+15) with ACC_W=6 -> wrap acc_out=56, ovf=1; saturate acc_out=63.
